red_ctrl: RTL and testbench

Multi-cycle sequencer for the reduced RISC-V datapath (register file, ALU with immediate mux, data memory, result mux). Accepts one 32-bit instruction at a time over a valid/ready fetch handshake, decodes it, and drives the register addresses, immediate and per-phase control strobes (RegWrite, ALUctrl, ALUsrc, MemWrite, ResultSrc) so that each instruction completes in a fixed phase sequence. Owns the program counter and the branch decision from the ALU Zero flag.

---
 rtl/red_ctrl_pkg.sv | 110 +++++++++++
 rtl/red_ctrl_if.sv | 34 +++
 rtl/red_ctrl_imm_gen.sv | 25 ++
 rtl/red_ctrl.sv | 121 ++++++++++++
 tb/tb_red_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/red_ctrl_pkg.sv
// Shared state encoding, RV32 opcode/funct constants, ALU codes and the
// instruction decode helper for the red_ctrl sequencer.
package red_ctrl_pkg;
   localparam int DATA_WIDTH    = 32;
   localparam int ADDRESS_WIDTH = 5;
   localparam int ALUctrl_WIDTH = 3;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEM,
      S_WRITEBACK,
      S_TRAP
   } state_t;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_WORD = 3'b010;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   localparam logic [ALUctrl_WIDTH-1:0] ALU_ADD = 3'b000;
   localparam logic [ALUctrl_WIDTH-1:0] ALU_SUB = 3'b001;
   localparam logic [ALUctrl_WIDTH-1:0] ALU_AND = 3'b010;
   localparam logic [ALUctrl_WIDTH-1:0] ALU_OR  = 3'b011;

   // Field layout matches the RV32 base encoding bit-for-bit.
   typedef struct packed {
      logic [6:0]               funct7;
      logic [ADDRESS_WIDTH-1:0] rs2;
      logic [ADDRESS_WIDTH-1:0] rs1;
      logic [2:0]               funct3;
      logic [ADDRESS_WIDTH-1:0] rd;
      logic [6:0]               opcode;
   } fields_t;

   typedef struct packed {
      logic                     legal;
      logic                     is_load;
      logic                     is_store;
      logic                     is_branch;
      logic                     use_imm;
      logic [ALUctrl_WIDTH-1:0] alu_op;
   } dec_t;

   function automatic dec_t decode(input fields_t f);
      dec_t d;
      d = '0;
      case (f.opcode)
         OPC_R: begin
            if (f.funct7 == F7_BASE) begin
               case (f.funct3)
                  F3_ADD:  begin d.legal = 1'b1; d.alu_op = ALU_ADD; end
                  F3_AND:  begin d.legal = 1'b1; d.alu_op = ALU_AND; end
                  F3_OR:   begin d.legal = 1'b1; d.alu_op = ALU_OR;  end
                  default: ;
               endcase
            end else if (f.funct7 == F7_SUB && f.funct3 == F3_ADD) begin
               d.legal  = 1'b1;
               d.alu_op = ALU_SUB;
            end
         end
         OPC_I: begin
            d.use_imm = 1'b1;
            case (f.funct3)
               F3_ADD:  begin d.legal = 1'b1; d.alu_op = ALU_ADD; end
               F3_AND:  begin d.legal = 1'b1; d.alu_op = ALU_AND; end
               F3_OR:   begin d.legal = 1'b1; d.alu_op = ALU_OR;  end
               default: ;
            endcase
         end
         OPC_LOAD: begin
            if (f.funct3 == F3_WORD) begin
               d.legal   = 1'b1;
               d.is_load = 1'b1;
               d.use_imm = 1'b1;
               d.alu_op  = ALU_ADD;
            end
         end
         OPC_STORE: begin
            if (f.funct3 == F3_WORD) begin
               d.legal    = 1'b1;
               d.is_store = 1'b1;
               d.use_imm  = 1'b1;
               d.alu_op   = ALU_ADD;
            end
         end
         OPC_BRANCH: begin
            if (f.funct3 == F3_BEQ || f.funct3 == F3_BNE) begin
               d.legal     = 1'b1;
               d.is_branch = 1'b1;
               d.alu_op    = ALU_SUB;
            end
         end
         default: ;
      endcase
      return d;
   endfunction
endpackage

// File: rtl/red_ctrl_if.sv
// Fetch handshake, ALU/memory status and datapath control bundle.
// master = sequencer side, slave = fetch source / datapath side.
interface red_ctrl_if;
   import red_ctrl_pkg::*;

   logic                     instr_valid;
   logic [DATA_WIDTH-1:0]    instr;
   logic                     instr_ready;
   logic                     Zero;
   logic                     mem_ready;
   logic [ADDRESS_WIDTH-1:0] rs1;
   logic [ADDRESS_WIDTH-1:0] rs2;
   logic [ADDRESS_WIDTH-1:0] rd;
   logic [DATA_WIDTH-1:0]    ImmOp;
   logic [ALUctrl_WIDTH-1:0] ALUctrl;
   logic                     ALUsrc;
   logic                     RegWrite;
   logic                     MemWrite;
   logic                     ResultSrc;
   logic [DATA_WIDTH-1:0]    PC;
   logic                     illegal;

   modport master (
      input  instr_valid, instr, Zero, mem_ready,
      output instr_ready, rs1, rs2, rd, ImmOp, ALUctrl, ALUsrc,
             RegWrite, MemWrite, ResultSrc, PC, illegal
   );

   modport slave (
      output instr_valid, instr, Zero, mem_ready,
      input  instr_ready, rs1, rs2, rd, ImmOp, ALUctrl, ALUsrc,
             RegWrite, MemWrite, ResultSrc, PC, illegal
   );
endinterface

// File: rtl/red_ctrl_imm_gen.sv
// Combinational field split and format-dependent immediate sign extension;
// zero latency, no flow control.
module imm_gen
   import red_ctrl_pkg::*;
(
   input  logic [DATA_WIDTH-1:0] instr,
   output fields_t               fields,
   output logic [DATA_WIDTH-1:0] imm
);
   assign fields = fields_t'(instr);

   always_comb begin
      imm = '0;
      case (instr[6:0])
         OPC_I, OPC_LOAD:
            imm = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
         OPC_STORE:
            imm = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
         OPC_BRANCH:
            imm = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7],
                   instr[30:25], instr[11:8], 1'b0};
         default: ;
      endcase
   end
endmodule

// File: rtl/red_ctrl.sv
// Multi-cycle sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK/TRAP, 3-5 cycles
// per instruction; takes a new instruction only in FETCH, MEM stalls on mem_ready.
module red_ctrl
   import red_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   red_ctrl_if.master bus
);
   state_t                state;
   state_t                state_nxt;
   logic [DATA_WIDTH-1:0] ir;
   logic [DATA_WIDTH-1:0] pc;
   logic [DATA_WIDTH-1:0] pc_nxt;
   logic [DATA_WIDTH-1:0] imm;
   logic                  pc_upd;
   logic                  taken;
   fields_t               fld;
   dec_t                  dec;

   imm_gen u_imm_gen (
      .instr  (ir),
      .fields (fld),
      .imm    (imm)
   );

   assign dec   = decode(fld);
   assign taken = (fld.funct3 == F3_BNE) ? ~bus.Zero : bus.Zero;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:     if (bus.instr_valid) state_nxt = S_DECODE;
         S_DECODE:    state_nxt = dec.legal ? S_EXECUTE : S_TRAP;
         S_EXECUTE: begin
            if (dec.is_branch) begin
               state_nxt = S_FETCH;
            end else if (dec.is_load || dec.is_store) begin
               state_nxt = S_MEM;
            end else begin
               state_nxt = S_WRITEBACK;
            end
         end
         S_MEM:       if (bus.mem_ready) state_nxt = dec.is_store ? S_FETCH : S_WRITEBACK;
         S_WRITEBACK: state_nxt = S_FETCH;
         S_TRAP:      state_nxt = S_TRAP;
         default:     state_nxt = S_FETCH;
      endcase
   end

   // PC advances only on the edge that retires the instruction.
   always_comb begin
      pc_upd = 1'b0;
      pc_nxt = pc + 32'd4;
      case (state)
         S_EXECUTE: begin
            if (dec.is_branch) begin
               pc_upd = 1'b1;
               if (taken) pc_nxt = pc + imm;
            end
         end
         S_MEM:       pc_upd = bus.mem_ready & dec.is_store;
         S_WRITEBACK: pc_upd = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir <= '0;
         pc <= '0;
      end else begin
         if (state == S_FETCH && bus.instr_valid) ir <= bus.instr;
         if (pc_upd) pc <= pc_nxt;
      end
   end

   assign bus.rs1   = fld.rs1;
   assign bus.rs2   = fld.rs2;
   assign bus.rd    = fld.rd;
   assign bus.ImmOp = imm;
   assign bus.PC    = pc;

   always_comb begin
      bus.instr_ready = 1'b0;
      bus.ALUctrl     = ALU_ADD;
      bus.ALUsrc      = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.ResultSrc   = 1'b0;
      bus.illegal     = 1'b0;
      case (state)
         S_FETCH:   bus.instr_ready = 1'b1;
         S_EXECUTE: begin
            bus.ALUctrl = dec.alu_op;
            bus.ALUsrc  = dec.use_imm;
         end
         S_MEM: begin
            bus.ALUctrl  = ALU_ADD;
            bus.ALUsrc   = 1'b1;
            bus.MemWrite = dec.is_store;
         end
         S_WRITEBACK: begin
            bus.ALUctrl   = dec.alu_op;
            bus.ALUsrc    = dec.use_imm;
            bus.RegWrite  = (fld.rd != '0);
            bus.ResultSrc = dec.is_load;
         end
         S_TRAP:    bus.illegal = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: tb/tb_red_ctrl.sv
// Directed bench for red_ctrl with an expectation queue per instruction.
module tb_red_ctrl;
   import red_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   red_ctrl_if bus ();

   red_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cycles;
      int          rw_cnt;
      int          mw_cnt;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [2:0]  alu;
      logic        alusrc;
      logic        rsrc;
      logic [31:0] pc;
   } exp_t;

   exp_t exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
      end
   endtask

   // Issue one instruction, watch it until FETCH returns, then score it.
   task automatic run(input string tag, input logic [31:0] word, input logic zero,
                      input int wait_c, input int cycles, input int rw, input int mw,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic [2:0] alu, input logic alusrc,
                      input logic rsrc, input logic [31:0] pc);
      exp_t        e;
      int          cyc = 0;
      int          rw_cnt = 0;
      int          mw_cnt = 0;
      logic        rsrc_seen = 1'b0;
      logic [4:0]  o_rd = '0;
      logic [4:0]  o_rs1 = '0;
      logic [4:0]  o_rs2 = '0;
      logic [31:0] o_imm = '0;
      logic [2:0]  alu_x = '0;
      logic        src_x = 1'b0;
      logic [2:0]  alu_l = '0;
      logic        src_l = 1'b0;
      e.cycles = cycles; e.rw_cnt = rw; e.mw_cnt = mw;
      e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
      e.alu = alu; e.alusrc = alusrc; e.rsrc = rsrc; e.pc = pc;
      exp_q.push_back(e);

      bus.instr       = word;
      bus.instr_valid = 1'b1;
      bus.Zero        = zero;
      bus.mem_ready   = 1'b0;
      while (1) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) bus.instr_valid = 1'b0;
         if (bus.instr_ready === 1'b1) break;
         if (cyc >= 40) begin
            check({tag, " back_to_fetch"}, {31'd0, bus.instr_ready}, 32'd1);
            break;
         end
         bus.mem_ready = (cyc >= 3 + wait_c);
         if (bus.RegWrite === 1'b1) rw_cnt++;
         if (bus.MemWrite === 1'b1) mw_cnt++;
         if (bus.ResultSrc === 1'b1) rsrc_seen = 1'b1;
         if (cyc == 2) begin
            o_rd = bus.rd; o_rs1 = bus.rs1; o_rs2 = bus.rs2; o_imm = bus.ImmOp;
            alu_x = bus.ALUctrl; src_x = bus.ALUsrc;
         end
         alu_l = bus.ALUctrl;
         src_l = bus.ALUsrc;
      end
      bus.mem_ready = 1'b0;

      e = exp_q.pop_front();
      check({tag, " cycles"},      cyc,       e.cycles);
      check({tag, " RegWrite_n"},  rw_cnt,    e.rw_cnt);
      check({tag, " MemWrite_n"},  mw_cnt,    e.mw_cnt);
      check({tag, " rd"},          o_rd,      e.rd);
      check({tag, " rs1"},         o_rs1,     e.rs1);
      check({tag, " rs2"},         o_rs2,     e.rs2);
      check({tag, " ImmOp"},       o_imm,     e.imm);
      check({tag, " ALUctrl_ex"},  alu_x,     e.alu);
      check({tag, " ALUsrc_ex"},   src_x,     e.alusrc);
      check({tag, " ALUctrl_end"}, alu_l,     e.alu);
      check({tag, " ALUsrc_end"},  src_l,     e.alusrc);
      check({tag, " ResultSrc"},   rsrc_seen, e.rsrc);
      check({tag, " PC"},          bus.PC,    e.pc);
      check({tag, " illegal"},     bus.illegal, 1'b0);
   endtask

   initial begin
      rst             = 1'b1;
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      bus.Zero        = 1'b0;
      bus.mem_ready   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_hold instr_ready", bus.instr_ready, 1'b1);
      rst = 1'b0;
      #1;
      check("reset PC",          bus.PC,          32'h0);
      check("reset instr_ready", bus.instr_ready, 1'b1);
      check("reset RegWrite",    bus.RegWrite,    1'b0);
      check("reset MemWrite",    bus.MemWrite,    1'b0);
      check("reset illegal",     bus.illegal,     1'b0);
      check("reset ImmOp",       bus.ImmOp,       32'h0);
      check("reset rd",          bus.rd,          5'd0);

      //   tag       instr         Z  wt cyc rw mw rd  rs1 rs2 imm           alu src rsrc pc
      run("addi",    32'h00500513, 0, 0, 4,  1, 0, 10, 0,  5,  32'd5,        0,  1,  0,   32'h04);
      run("sub",     32'h402081B3, 0, 0, 4,  1, 0, 3,  1,  2,  32'd0,        1,  0,  0,   32'h08);
      run("add_x0",  32'h00000033, 0, 0, 4,  0, 0, 0,  0,  0,  32'd0,        0,  0,  0,   32'h0C);
      run("sw",      32'h0020A423, 0, 2, 6,  0, 3, 8,  1,  2,  32'd8,        0,  1,  0,   32'h10);
      run("lw",      32'h0080A283, 0, 1, 6,  1, 0, 5,  1,  8,  32'd8,        0,  1,  1,   32'h14);
      run("or",      32'h0020E333, 0, 0, 4,  1, 0, 6,  1,  2,  32'd0,        3,  0,  0,   32'h18);
      run("andi",    32'hFFF0F393, 0, 0, 4,  1, 0, 7,  1,  31, 32'hFFFFFFFF, 2,  1,  0,   32'h1C);
      run("beq_nt",  32'h00108063, 0, 0, 3,  0, 0, 0,  1,  1,  32'd0,        1,  0,  0,   32'h20);
      run("bne_tk",  32'hFE209CE3, 0, 0, 3,  0, 0, 25, 1,  2,  32'hFFFFFFF8, 1,  0,  0,   32'h18);
      run("beq_tk",  32'h00108463, 1, 0, 3,  0, 0, 8,  1,  1,  32'd8,        1,  0,  0,   32'h20);
      run("bne_nt",  32'hFE209CE3, 1, 0, 3,  0, 0, 25, 1,  2,  32'hFFFFFFF8, 1,  0,  0,   32'h24);

      // Unsupported encoding traps and stays trapped with a source still offering work.
      bus.instr       = 32'hFFFFFFFF;
      bus.instr_valid = 1'b1;
      repeat (2) @(negedge clk);
      check("trap illegal",     bus.illegal,     1'b1);
      check("trap instr_ready", bus.instr_ready, 1'b0);
      repeat (8) @(negedge clk);
      check("trap_hold illegal",     bus.illegal,     1'b1);
      check("trap_hold instr_ready", bus.instr_ready, 1'b0);
      check("trap_hold PC",          bus.PC,          32'h24);
      check("trap_hold RegWrite",    bus.RegWrite,    1'b0);
      bus.instr_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("trap_rst PC",          bus.PC,          32'h0);
      check("trap_rst illegal",     bus.illegal,     1'b0);
      check("trap_rst instr_ready", bus.instr_ready, 1'b1);
      check("trap_rst rd",          bus.rd,          5'd0);
      @(negedge clk);
      rst = 1'b0;

      // Reset in the middle of a stalled store.
      bus.instr       = 32'h0020A423;
      bus.instr_valid = 1'b1;
      bus.mem_ready   = 1'b0;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("midmem MemWrite", bus.MemWrite, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("midmem_rst MemWrite",    bus.MemWrite,    1'b0);
      check("midmem_rst instr_ready", bus.instr_ready, 1'b1);
      check("midmem_rst PC",          bus.PC,          32'h0);
      check("midmem_rst rs1",         bus.rs1,         5'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      run("addi_again", 32'h00500513, 0, 0, 4, 1, 0, 10, 0, 5, 32'd5, 0, 1, 0, 32'h04);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
